sr_bank_driver: RTL



---
 rtl/sr_pkg.sv | 33 +++
 rtl/sr_phase_timer.sv | 32 +++
 rtl/sr_bank_driver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank driver.
//   sr_drv_state_t : driver FSM states
//   SR_DEF_*       : default parameter values for sr_bank_driver
//   sr_excite()    : per-bit set/reset excitation for a target/current Q pair
package sr_pkg;

    localparam int unsigned SR_DEF_WIDTH         = 8;
    localparam int unsigned SR_DEF_PULSE_CYCLES  = 2;
    localparam int unsigned SR_DEF_SETTLE_CYCLES = 1;
    localparam int unsigned SR_DEF_MAX_RETRY     = 2;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK
    } sr_drv_state_t;

    typedef struct packed {
        logic s;
        logic r;
    } sr_excite_t;

    // Set only bits that must rise, reset only bits that must fall; s and r
    // are mutually exclusive for any input pair.
    function automatic sr_excite_t sr_excite(input logic target, input logic q);
        sr_excite_t e;
        e.s = target & ~q;
        e.r = ~target & q;
        return e;
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter timing the PULSE and SETTLE phases.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one; holds at zero, never wraps
//   load_val  : value to load
//   zero      : counter is zero (last cycle of the current phase)
module sr_phase_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// Write initiator for a bank of SR flip-flops: pulses per-bit set/reset
// excitations, lets the bank settle, reads Q back and retries on mismatch.
//   clk, rst        : clock, asynchronous active-high reset
//   wr_valid/ready  : write handshake (ready only while idle)
//   wr_data         : target Q value
//   q_in            : bank Q readback
//   s_out, r_out    : set / reset excitations (never both high on a bit)
//   busy            : write in progress
//   done, err       : one-cycle pulse, write verified / retries exhausted
// PULSE_CYCLES and SETTLE_CYCLES must be at least 1.
module sr_bank_driver
    import sr_pkg::*;
#(
    parameter int unsigned WIDTH         = SR_DEF_WIDTH,
    parameter int unsigned PULSE_CYCLES  = SR_DEF_PULSE_CYCLES,
    parameter int unsigned SETTLE_CYCLES = SR_DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRY     = SR_DEF_MAX_RETRY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned PHASE_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES
                                                                       : SETTLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
    // Keep at least one bit so MAX_RETRY = 0 still elaborates.
    localparam int unsigned RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Timer counts down to zero, so load duration minus one.
    localparam logic [CNT_W-1:0]   PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY);

    sr_drv_state_t      state_q, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WIDTH-1:0]   s_d, r_d;
    logic               done_d, err_d, busy_d, ready_d;

    logic               tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]   tmr_val;

    logic [WIDTH-1:0]   mask_base, s_mask, r_mask;

    sr_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Masks are needed on accept (against the incoming data) and on retry
    // (against the latched target); one mask unit serves both.
    always_comb begin
        s_mask    = '0;
        r_mask    = '0;
        mask_base = (state_q == IDLE) ? wr_data : target_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {s_mask[i], r_mask[i]} = sr_excite(mask_base[i], q_in[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        retry_d  = retry_q;
        s_d      = '0;
        r_d      = '0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = PULSE_LOAD;

        unique case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    target_d = wr_data;
                    retry_d  = '0;
                    if ((s_mask | r_mask) == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d  = PULSE;
                        s_d      = s_mask;
                        r_d      = r_mask;
                        tmr_load = 1'b1;
                        tmr_val  = PULSE_LOAD;
                    end
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    state_d  = SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end else begin
                    s_d     = s_out;
                    r_d     = r_out;
                    tmr_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                if (q_in == target_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (retry_q != RETRY_LAST) begin
                    // A mismatch guarantees a non-zero mask, so PULSE is never empty.
                    state_d  = PULSE;
                    retry_d  = retry_q + RETRY_W'(1);
                    s_d      = s_mask;
                    r_d      = r_mask;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                end else begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            retry_q  <= '0;
            s_out    <= '0;
            r_out    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            retry_q  <= retry_d;
            s_out    <= s_d;
            r_out    <= r_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= busy_d;
            wr_ready <= ready_d;
        end
    end

endmodule
